// File: rtl/alu_tst_pkg.sv
// Shared constants, encodings and helpers for the on-chip 2-bit alu pattern applicator.
package alu_tst_pkg;

    localparam int NPI = 5;
    localparam int NPO = 2;

    // Bit positions inside the PI vector {ain[1],ain[0],bin[1],bin[0],sel}
    localparam int PI_SEL = 0;
    localparam int PI_B0  = 1;
    localparam int PI_B1  = 2;
    localparam int PI_A0  = 3;
    localparam int PI_A1  = 4;

    typedef enum logic [1:0] {
        FILL_ZERO     = 2'd0,
        FILL_ONE      = 2'd1,
        FILL_ADJ      = 2'd2,
        FILL_ZERO_ALT = 2'd3
    } fill_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_APPLY   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_MEASURE = 3'd3,
        ST_DONE    = 3'd4
    } seq_state_e;

    typedef struct packed {
        logic [NPI-1:0] pi;
        logic [NPI-1:0] care;
        logic [NPO-1:0] xpct;
        logic [NPO-1:0] mask;
    } pat_entry_t;

    function automatic logic [2:0] popcount5(input logic [NPI-1:0] v);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < NPI; i++) begin
            c = c + {2'b00, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/alu_pat_mem.sv
// Pattern register file: one synchronous write port, one combinational read port.
module alu_pat_mem
    import alu_tst_pkg::*;
#(
    parameter int NPAT = 16,
    parameter int AW   = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  pat_entry_t    wdata,
    input  logic [AW-1:0] raddr,
    output pat_entry_t    rdata
);

    pat_entry_t mem_r [NPAT];

    // Storage write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/alu_test_sequencer.sv
// Applies stored, X-filled patterns to the alu pins, checks zout under mask and
// accumulates fail and pin-toggle statistics for the run.
module alu_test_sequencer
    import alu_tst_pkg::*;
#(
    parameter int NPAT       = 16,
    parameter int SETTLE_CYC = 2,
    parameter int TW         = 16,
    localparam int AW        = $clog2(NPAT)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_we,
    input  logic [AW-1:0]  cfg_addr,
    input  logic [4:0]     cfg_pi,
    input  logic [4:0]     cfg_pi_care,
    input  logic [1:0]     cfg_xpct,
    input  logic [1:0]     cfg_mask,
    input  logic [AW:0]    num_pat,
    input  logic [1:0]     fill_mode,
    input  logic           start,
    output logic [1:0]     ain,
    output logic [1:0]     bin,
    output logic           sel,
    input  logic [1:0]     zout,
    output logic           busy,
    output logic           done,
    output logic [AW-1:0]  pat_idx,
    output logic [AW:0]    fail_cnt,
    output logic           first_fail_vld,
    output logic [AW-1:0]  first_fail_idx,
    output logic [TW-1:0]  toggle_cnt
);

    localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    seq_state_e     state_r;
    fill_mode_e     fmode_r;
    logic [AW:0]    npat_r;
    logic [SCW-1:0] settle_r;
    logic [NPI-1:0] pins_r;
    logic           busy_r;
    logic           done_r;
    logic [AW-1:0]  pat_idx_r;
    logic [AW:0]    fail_cnt_r;
    logic           ff_vld_r;
    logic [AW-1:0]  ff_idx_r;
    logic [TW-1:0]  toggle_r;

    pat_entry_t     wr_entry_s;
    pat_entry_t     rd_entry_s;
    logic           mem_we_s;
    logic [NPI-1:0] fill_s;
    logic [NPI-1:0] filled_s;
    logic [2:0]     flips_s;
    logic [TW:0]    tog_sum_s;
    logic           mis_s;
    logic           last_s;
    logic [AW:0]    npat_clamp_s;

    // Memory is frozen while a run is in progress
    assign mem_we_s   = cfg_we & ~busy_r;
    assign wr_entry_s = '{pi: cfg_pi, care: cfg_pi_care, xpct: cfg_xpct, mask: cfg_mask};

    alu_pat_mem #(
        .NPAT (NPAT),
        .AW   (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (cfg_addr),
        .wdata (wr_entry_s),
        .raddr (pat_idx_r),
        .rdata (rd_entry_s)
    );

    // X-fill, toggle accounting, masked compare and run-length bookkeeping
    always_comb begin
        fill_s = {NPI{1'b0}};
        case (fmode_r)
            FILL_ONE: fill_s = {NPI{1'b1}};
            FILL_ADJ: fill_s = pins_r;
            default:  fill_s = {NPI{1'b0}};
        endcase
        filled_s  = (rd_entry_s.pi & rd_entry_s.care) | (fill_s & ~rd_entry_s.care);
        flips_s   = popcount5(filled_s ^ pins_r);
        tog_sum_s = {1'b0, toggle_r} + {{(TW-2){1'b0}}, flips_s};
        mis_s     = |((zout ^ rd_entry_s.xpct) & rd_entry_s.mask);
        last_s    = ({1'b0, pat_idx_r} == (npat_r - {{AW{1'b0}}, 1'b1}));
        if (num_pat > (AW+1)'(NPAT)) begin
            npat_clamp_s = (AW+1)'(NPAT);
        end else begin
            npat_clamp_s = num_pat;
        end
    end

    // Sequencer FSM with all results and pin drivers registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            fmode_r    <= FILL_ZERO;
            npat_r     <= '0;
            settle_r   <= '0;
            pins_r     <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pat_idx_r  <= '0;
            fail_cnt_r <= '0;
            ff_vld_r   <= 1'b0;
            ff_idx_r   <= '0;
            toggle_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        fail_cnt_r <= '0;
                        ff_vld_r   <= 1'b0;
                        ff_idx_r   <= '0;
                        toggle_r   <= '0;
                        pat_idx_r  <= '0;
                        npat_r     <= npat_clamp_s;
                        fmode_r    <= fill_mode_e'(fill_mode);
                        if (num_pat == '0) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_APPLY;
                            busy_r  <= 1'b1;
                        end
                    end
                end
                ST_APPLY: begin
                    pins_r   <= filled_s;
                    toggle_r <= tog_sum_s[TW] ? {TW{1'b1}} : tog_sum_s[TW-1:0];
                    settle_r <= '0;
                    state_r  <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_r == SCW'(SETTLE_CYC - 1)) begin
                        state_r <= ST_MEASURE;
                    end else begin
                        settle_r <= settle_r + {{(SCW-1){1'b0}}, 1'b1};
                    end
                end
                ST_MEASURE: begin
                    if (mis_s) begin
                        if (fail_cnt_r != {(AW+1){1'b1}}) begin
                            fail_cnt_r <= fail_cnt_r + {{AW{1'b0}}, 1'b1};
                        end
                        if (!ff_vld_r) begin
                            ff_vld_r <= 1'b1;
                            ff_idx_r <= pat_idx_r;
                        end
                    end
                    if (last_s) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        pat_idx_r <= pat_idx_r + {{(AW-1){1'b0}}, 1'b1};
                        state_r   <= ST_APPLY;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign ain            = {pins_r[PI_A1], pins_r[PI_A0]};
    assign bin            = {pins_r[PI_B1], pins_r[PI_B0]};
    assign sel            = pins_r[PI_SEL];
    assign busy           = busy_r;
    assign done           = done_r;
    assign pat_idx        = pat_idx_r;
    assign fail_cnt       = fail_cnt_r;
    assign first_fail_vld = ff_vld_r;
    assign first_fail_idx = ff_idx_r;
    assign toggle_cnt     = toggle_r;

endmodule
